// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and defaults for the APB requester
// Purpose: FSM state encoding and default bus widths used by apb_master.
// Ports: none (package).
package apb_pkg;

  // 2'b11 is unused; the FSM falls back to IDLE if it ever appears.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int unsigned DEF_DATAWIDTH = 8;
  localparam int unsigned DEF_ADDRWIDTH = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating ACCESS-phase wait counter
// Purpose: counts ACCESS cycles and flags the last cycle allowed before a timeout.
// Ports:
//   clk_i      clock, rising edge
//   clear_i    synchronous clear (has priority over enable)
//   enable_i   count this cycle
//   expired_o  high while the count equals TIMEOUT-1
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Stops at LAST so the counter can never wrap back into a non-expired value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - host command to APB SETUP/ACCESS requester, two slaves
// Purpose: turns one host command into one APB transfer with PREADY timeout.
// Ports:
//   PCLK, PRESET                  clock and sync active-high reset
//   cmd_valid/ready/write/addr/wdata   host command port; addr MSB picks slave
//   rsp_valid/rdata/err           one-cycle response pulse, data/err held
//   PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA   APB request side
//   PRDATA1, PRDATA2, PREADY      APB responder side
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH:0]   cmd_addr,
  input  logic [DATAWIDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 PSEL1,
  output logic                 PSEL2,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0] PWDATA,
  input  logic [DATAWIDTH-1:0] PRDATA1,
  input  logic [DATAWIDTH-1:0] PRDATA2,
  input  logic                 PREADY
);

  apb_state_e           state_q, state_d;
  logic                 sel2_q, sel2_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
  logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 expired;
  logic                 done;
  logic                 busy;
  logic [DATAWIDTH-1:0] prdata_sel;

  // Ready is withheld during reset so a command seen then is never accepted.
  assign cmd_ready  = (state_q == IDLE) && !PRESET;
  assign busy       = (state_q == SETUP) || (state_q == ACCESS);
  assign done       = (state_q == ACCESS) && (PREADY || expired);
  assign prdata_sel = sel2_q ? PRDATA2 : PRDATA1;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (PCLK),
    .clear_i   (PRESET || (state_q != ACCESS) || done),
    .enable_i  (state_q == ACCESS),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    sel2_d      = sel2_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d  = SETUP;
          sel2_d   = cmd_addr[ADDRWIDTH];
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr[ADDRWIDTH-1:0];
          pwdata_d = cmd_wdata;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // PREADY is checked first so a late ready on the final cycle still succeeds.
        if (PREADY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : prdata_sel;
        end else if (expired) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      sel2_q      <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel2_q      <= sel2_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSEL1     = busy && !sel2_q;
  assign PSEL2     = busy && sel2_q;
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master
module tb_apb_master;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [8:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;
  logic       PREADY;

  int total = 0;
  int bad   = 0;

  apb_master #(.DATAWIDTH(8), .ADDRWIDTH(8), .TIMEOUT(16)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL1     (PSEL1),
    .PSEL2     (PSEL2),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA1   (PRDATA1),
    .PRDATA2   (PRDATA2),
    .PREADY    (PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       write;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] prd1;
    logic [7:0] prd2;
    int         waits;     // PREADY-low ACCESS cycles before PREADY=1
    logic       psel1;     // 1: slave1 expected, 0: slave2
    int         exp_acc;   // ACCESS cycles expected
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  acc;
    bit  done;
    @(negedge PCLK);
    check("ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    PRDATA1 = v.prd1; PRDATA2 = v.prd2;
    PREADY = 1'b1;  // left high through IDLE/SETUP; must be ignored there
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("setup_psel1", 32'(PSEL1), 32'(v.psel1));
    check("setup_psel2", 32'(PSEL2), 32'(!v.psel1));
    check("setup_penable", 32'(PENABLE), 0);
    check("setup_paddr", 32'(PADDR), 32'(v.addr[7:0]));
    check("setup_pwrite", 32'(PWRITE), 32'(v.write));
    check("setup_pwdata", 32'(PWDATA), 32'(v.wdata));
    acc = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        done = 1;
      end else begin
        acc++;
        check("access_penable", 32'(PENABLE), 1);
        check("access_psel_one", 32'({PSEL1, PSEL2}), v.psel1 ? 2 : 1);
        check("access_paddr", 32'(PADDR), 32'(v.addr[7:0]));
        PREADY = ((acc - 1) == v.waits);
      end
    end
    PREADY = 1'b1;
    check("rsp_seen", 32'(done), 1);
    check("access_cycles", 32'(acc), 32'(v.exp_acc));
    check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    check("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
    check("rsp_bus_idle", 32'({PSEL1, PSEL2, PENABLE}), 0);
    check("rsp_cmd_ready", 32'(cmd_ready), 1);
    @(negedge PCLK);
    check("rsp_pulse_once", 32'(rsp_valid), 0);
    check("rdata_hold", 32'(rsp_rdata), 32'(v.exp_rdata));
    check("paddr_hold", 32'(PADDR), 32'(v.addr[7:0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int p1, p2, npulse;
    bit overlap;
    logic [7:0] rd1, rd2;
    logic s1, s4;

    vecs[0] = '{1'b1, 9'h012, 8'hA5, 8'h77, 8'h88, 0,   1'b1, 1,  8'h00, 1'b0};
    vecs[1] = '{1'b0, 9'h134, 8'h00, 8'h11, 8'h5C, 2,   1'b0, 3,  8'h5C, 1'b0};
    vecs[2] = '{1'b0, 9'h0FF, 8'h00, 8'hC3, 8'h99, 0,   1'b1, 1,  8'hC3, 1'b0};
    vecs[3] = '{1'b1, 9'h1AA, 8'h5A, 8'h12, 8'h34, 1,   1'b0, 2,  8'h00, 1'b0};
    vecs[4] = '{1'b0, 9'h020, 8'h00, 8'hEE, 8'hDD, 255, 1'b1, 16, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 9'h045, 8'h00, 8'h3C, 8'hAB, 15,  1'b1, 16, 8'h3C, 1'b0};
    vecs[6] = '{1'b1, 9'h1FF, 8'hF0, 8'h00, 8'h00, 255, 1'b0, 16, 8'h00, 1'b1};

    PRESET = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h0AB;
    cmd_wdata = 8'h99; PRDATA1 = 8'h00; PRDATA2 = 8'h00; PREADY = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_psel", 32'({PSEL1, PSEL2, PENABLE}), 0);
    check("rst_pwrite", 32'(PWRITE), 0);
    check("rst_paddr", 32'(PADDR), 0);
    check("rst_pwdata", 32'(PWDATA), 0);
    check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 0);
    PRESET = 1'b0; cmd_valid = 1'b0;
    @(negedge PCLK);
    check("rst_cmd_dropped", 32'({PSEL1, PSEL2}), 0);
    check("rst_ready_after", 32'(cmd_ready), 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // back-to-back: second command accepted in the rsp_valid cycle
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h001; cmd_wdata = 8'h33;
    PREADY = 1'b1; PRDATA1 = 8'h44; PRDATA2 = 8'h6D;
    p1 = -1; p2 = -1; npulse = 0; overlap = 0; rd1 = 8'hFF; rd2 = 8'hFF; s1 = 0; s4 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge PCLK);
      if (PSEL1 && PSEL2) overlap = 1;
      if (rsp_valid) begin
        npulse++;
        if (npulse == 1) begin p1 = c; rd1 = rsp_rdata; end
        else begin p2 = c; rd2 = rsp_rdata; end
      end
      if (c == 1) begin s1 = PSEL1; cmd_write = 1'b0; cmd_addr = 9'h101; end
      if (c == 4) begin s4 = PSEL2; cmd_valid = 1'b0; end
    end
    check("b2b_pulses", 32'(npulse), 2);
    check("b2b_first_at", 32'(p1), 3);
    check("b2b_second_at", 32'(p2), 6);
    check("b2b_rd1", 32'(rd1), 8'h00);
    check("b2b_rd2", 32'(rd2), 8'h6D);
    check("b2b_psel1", 32'(s1), 1);
    check("b2b_psel2", 32'(s4), 1);
    check("b2b_overlap", 32'(overlap), 0);

    // reset during ACCESS
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h055; cmd_wdata = 8'h7E; PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("mid_in_access", 32'(PENABLE), 1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("mid_bus_zero", 32'({PSEL1, PSEL2, PENABLE, PWRITE}), 0);
    check("mid_paddr_zero", 32'(PADDR), 0);
    check("mid_pwdata_zero", 32'(PWDATA), 0);
    check("mid_no_rsp", 32'(rsp_valid), 0);
    check("mid_ready_in_rst", 32'(cmd_ready), 0);
    PRESET = 1'b0; PREADY = 1'b1;
    @(negedge PCLK);
    check("mid_no_rsp_after", 32'(rsp_valid), 0);
    check("mid_ready_after", 32'(cmd_ready), 1);
    check("mid_bus_idle", 32'({PSEL1, PSEL2, PENABLE}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
